// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and queues {pc, inst} for IF/ID.
// Optional perf counters are compiled in with `define IF_FETCH_PERF_CNT_EN.
module if_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_en_if,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
`ifdef IF_FETCH_PERF_CNT_EN
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count,
`endif
    input  logic        out_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc, drop_addr, last_pc;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_inst [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [AW+1:0] count_ext, count_post;
    logic          push, pop, issue_idle, issue_cont;

    assign out_valid  = (count != '0);
    assign push       = (state == REQ) && imem_ack && !redirect_valid;
    assign pop        = out_valid && out_ready && !redirect_valid;
    assign count_ext  = {1'b0, count};
    assign count_post = count_ext + {{(AW+1){1'b0}}, push} - {{(AW+1){1'b0}}, pop};
    // Continuing in REQ looks at the post-push/pop occupancy so a full-rate stream needs only two entries.
    assign issue_idle = pc_en_if && !redirect_valid && (count_ext < DEPTH_W);
    assign issue_cont = pc_en_if && !redirect_valid && (count_post < DEPTH_W);

    assign imem_req  = (state != IDLE);
    assign imem_addr = (state == DROP) ? drop_addr : pc;
    assign out_pc    = out_valid ? q_pc[rd_ptr]   : last_pc;
    assign out_inst  = out_valid ? q_inst[rd_ptr] : NOP_INST;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue_idle) state_nxt = REQ;
            REQ: begin
                if (redirect_valid)  state_nxt = imem_ack ? IDLE : DROP;
                else if (imem_ack)   state_nxt = issue_cont ? REQ : IDLE;
            end
            DROP: if (imem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
            last_pc   <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                pc     <= {redirect_pc[31:2], 2'b00};
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                // The in-flight address must stay on the bus until memory answers.
                if (state == REQ) drop_addr <= pc;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    pc     <= pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr  <= rd_ptr + AW'(1);
                    last_pc <= q_pc[rd_ptr];
                end
                count <= count_post[AW:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= pc;
            q_inst[wr_ptr] <= imem_rdata;
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    logic stall_inc;
    assign stall_inc = !pc_en_if || ((state == REQ) && !imem_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (stall_inc && (perf_stall_cycles != 32'hFFFF_FFFF))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (redirect_valid && (perf_flush_count != 32'hFFFF_FFFF))
                perf_flush_count <= perf_flush_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a stream-level model of fetch order, queue occupancy and memory handshake.
module tb_if_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, pc_en_if, redirect_valid, imem_req, imem_ack, out_valid, out_ready;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, out_pc, out_inst;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

    if_fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc_en_if(pc_en_if),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
`ifdef IF_FETCH_PERF_CNT_EN
        .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16] ^ a[15:0] ^ 16'h1234};
    endfunction

    // Stream-level model
    int          occ, lat, wait_cnt, max_lat, pops;
    logic [31:0] head_pc, fetch_pc, last_pop, prev_addr;
    bit          dropping, prev_req, prev_ack, prev_en, prev_redir, prev_rst;
    longint      stall_m, flush_m;

    task automatic step();
        bit push, pop;
        logic [31:0] tgt;
        imem_ack   = imem_req && (wait_cnt >= lat);
        imem_rdata = img(imem_addr);
        #1;
        if (!rst) begin
            if (prev_rst) begin
                chk("rst_req",   32'(imem_req),  32'd0);
                chk("rst_addr",  imem_addr,      32'h0);
                chk("rst_valid", 32'(out_valid), 32'd0);
                chk("rst_pc",    out_pc,         32'h0);
                chk("rst_inst",  out_inst,       32'h13);
            end else begin
                chk("out_valid", 32'(out_valid), 32'(occ > 0));
                if (occ > 0) begin
                    chk("out_pc",   out_pc,   head_pc);
                    chk("out_inst", out_inst, img(head_pc));
                end else begin
                    chk("empty_pc",   out_pc,   last_pop);
                    chk("empty_inst", out_inst, 32'h13);
                end
                if (dropping) chk("drop_req", 32'(imem_req), 32'd1);
                if (prev_req && !prev_ack) begin
                    chk("req_hold",  32'(imem_req), 32'd1);
                    chk("addr_hold", imem_addr, prev_addr);
                end else if (imem_req) begin
                    chk("issue_gate", 32'(prev_en && !prev_redir), 32'd1);
                    chk("issue_addr", imem_addr, fetch_pc);
                    chk("issue_room", 32'(occ < DEPTH), 32'd1);
                end
            end
        end

        if (rst) begin
            occ = 0; head_pc = 0; fetch_pc = 0; last_pop = 0; dropping = 0;
            wait_cnt = 0; lat = $urandom_range(0, max_lat); stall_m = 0; flush_m = 0;
        end else begin
            push = imem_req && imem_ack && !dropping && !redirect_valid;
            pop  = (occ > 0) && out_ready && !redirect_valid;
            if (!pc_en_if || (imem_req && !dropping && !imem_ack)) stall_m++;
            if (redirect_valid) flush_m++;
            if (pop) begin
                last_pop = head_pc;
                head_pc  = head_pc + 32'd4;
                pops++;
            end
            if (redirect_valid) begin
                tgt      = redirect_pc & 32'hFFFF_FFFC;
                occ      = 0;
                head_pc  = tgt;
                fetch_pc = tgt;
                dropping = imem_req && !imem_ack;
            end else begin
                occ = occ + int'(push) - int'(pop);
                if (push) fetch_pc = fetch_pc + 32'd4;
                if (dropping && imem_ack) dropping = 0;
            end
            if (imem_req && imem_ack) begin
                wait_cnt = 0;
                lat = $urandom_range(0, max_lat);
            end else if (imem_req) begin
                wait_cnt++;
            end
        end
        prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
        prev_en = pc_en_if; prev_redir = redirect_valid; prev_rst = rst;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        bit got_req;
        rst = 1'b1; pc_en_if = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        out_ready = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        max_lat = 0; lat = 0; wait_cnt = 0; pops = 0; occ = 0;
        prev_rst = 1'b1; dropping = 0; stall_m = 0; flush_m = 0;
        head_pc = 0; fetch_pc = 0; last_pop = 0; prev_addr = 0;
        prev_req = 0; prev_ack = 0; prev_en = 0; prev_redir = 0;
        @(negedge clk);
        do_reset();

        // Zero-latency memory, always ready: one instruction per cycle after a 2-cycle fill
        pops = 0;
        for (int i = 0; i < 20; i++) step();
        chk("throughput", 32'(pops), 32'd18);

        // Back-pressure fills the queue and stops fetching
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("full_req",   32'(imem_req),  32'd0);
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_occ",   32'(occ),       32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Random latency, back-pressure, gating and redirects (some near the wrap point)
        max_lat = 3;
        pops = 0;
        for (int i = 0; i < 3000; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            pc_en_if       = ($urandom_range(0, 4) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                         : ($urandom & 32'h0000_0FFF);
            step();
        end
        chk("random_progress", 32'(pops > 500), 32'd1);

        // Reset in the middle of an outstanding request
        out_ready = 1'b1; pc_en_if = 1'b1; redirect_valid = 1'b0; max_lat = 5;
        got_req = 0;
        for (int i = 0; i < 50 && !got_req; i++) begin
            step();
            if (imem_req && !dropping) got_req = 1;
        end
        chk("mid_req_seen", 32'(got_req), 32'd1);
        do_reset();
        step();

        // Perf window: gated cycles plus two redirects
        max_lat = 1;
        pc_en_if = 1'b0;
        for (int i = 0; i < 5; i++) step();
        pc_en_if = 1'b1;
        for (int i = 0; i < 2; i++) begin
            redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
            step();
            redirect_valid = 1'b0;
            step();
        end
        for (int i = 0; i < 8; i++) step();
`ifdef IF_FETCH_PERF_CNT_EN
        chk("perf_stall", perf_stall_cycles, 32'(stall_m));
        chk("perf_flush", perf_flush_count,  32'(flush_m));
        chk("perf_stall_min", 32'(perf_stall_cycles >= 32'd5), 32'd1);
`endif
        chk("final_pc_seen", 32'(pops > 0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
